// File: rtl/mips_multicycle_ctrl.sv
// Multicycle Moore control FSM for the 32-bit MIPS datapath: sequences
// fetch/decode/execute/memory/writeback, holds the memory handshake and traps.
module mips_multicycle_ctrl #(
   parameter int unsigned MEM_WAIT_MAX = 16,
   parameter int unsigned CNT_W        = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       alu_zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       ir_write,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] ext_sel,
   output logic [2:0] alu_op,
   output logic [1:0] pc_src,
   output logic [3:0] state,
   output logic       illegal
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_R_EXEC    = 4'd6,
      S_R_WB      = 4'd7,
      S_I_EXEC    = 4'd8,
      S_I_WB      = 4'd9,
      S_BRANCH    = 4'd10,
      S_JUMP      = 4'd11,
      S_TRAP      = 4'd15
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_LUI   = 6'b001111;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_FUNCT = 3'b010;
   localparam logic [2:0] ALU_AND   = 3'b011;
   localparam logic [2:0] ALU_OR    = 3'b100;
   localparam logic [2:0] ALU_SLT   = 3'b101;
   localparam logic [2:0] ALU_PASSB = 3'b110;

   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               wait_st;
   logic               timeout;

   assign wait_st = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                    (state_q == S_MEM_WRITE);
   // A ready in the last allowed cycle still completes the access.
   assign timeout = wait_st && !mem_ready && (cnt_q == WAIT_LAST);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:     if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:                                  state_d = S_R_EXEC;
               OP_LW, OP_SW:                              state_d = S_MEM_ADDR;
               OP_BEQ, OP_BNE:                            state_d = S_BRANCH;
               OP_J:                                      state_d = S_JUMP;
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: state_d = S_I_EXEC;
               default:                                   state_d = S_TRAP;
            endcase
         end
         S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
         S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
         S_R_EXEC:    state_d = S_R_WB;
         S_I_EXEC:    state_d = S_I_WB;
         S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
         S_TRAP:      state_d = S_TRAP;
         default:     state_d = S_TRAP;
      endcase
      if (timeout) state_d = S_TRAP;
   end

   // Counts consecutive stalled cycles; any state change or ready clears it.
   assign cnt_d = (wait_st && !mem_ready && (state_d == state_q)) ?
                  cnt_q + CNT_W'(1) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign state = state_q;

   // Moore decode; only FETCH (mem_ready) and BRANCH (alu_zero) gate pc_write.
   always_comb begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      ext_sel    = 2'b00;
      alu_op     = ALU_ADD;
      pc_src     = 2'b00;
      illegal    = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            pc_write  = mem_ready & rst_n;
            ir_write  = mem_ready & rst_n;
         end
         S_DECODE:    alu_src_b = 2'b11;
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEM_READ: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEM_WRITE: begin
            mem_write = 1'b1;
            iord      = 1'b1;
         end
         S_R_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_FUNCT;
         end
         S_R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_I_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            case (opcode)
               OP_ANDI: begin ext_sel = 2'b01; alu_op = ALU_AND;   end
               OP_ORI:  begin ext_sel = 2'b01; alu_op = ALU_OR;    end
               OP_SLTI: begin ext_sel = 2'b00; alu_op = ALU_SLT;   end
               OP_LUI:  begin ext_sel = 2'b10; alu_op = ALU_PASSB; end
               default: begin ext_sel = 2'b00; alu_op = ALU_ADD;   end
            endcase
         end
         S_I_WB:      reg_write = 1'b1;
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_SUB;
            pc_src    = 2'b01;
            pc_write  = (opcode == OP_BNE) ? !alu_zero : alu_zero;
         end
         S_JUMP: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
         end
         S_TRAP:      illegal = 1'b1;
         default:     illegal = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: per-cycle expected output vectors
// are queued as stimulus is driven and compared against the DUT at mid-cycle.
module tb_mips_multicycle_ctrl;

   logic       clk, rst_n, alu_zero, mem_ready;
   logic [5:0] opcode;
   logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write;
   logic       reg_dst, mem_to_reg, alu_src_a, illegal;
   logic [1:0] alu_src_b, ext_sel, pc_src;
   logic [2:0] alu_op;
   logic [3:0] state;

   typedef struct packed {
      logic [3:0] st;
      logic       pc_write, ir_write, iord, mem_read, mem_write;
      logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
      logic [1:0] alu_src_b, ext_sel;
      logic [2:0] alu_op;
      logic [1:0] pc_src;
      logic       illegal;
   } vec_t;

   vec_t sb[$];
   int   checks = 0;
   int   failures = 0;

   mips_multicycle_ctrl #(.MEM_WAIT_MAX(16), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
      .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_sel(ext_sel),
      .alu_op(alu_op), .pc_src(pc_src), .state(state), .illegal(illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs per state, written from the state table.
   function automatic vec_t ref_vec(input logic [3:0] st, input logic [5:0] opc,
                                    input logic rdy, input logic z);
      vec_t v = '0;
      v.st = st;
      case (st)
         4'd0: begin v.mem_read = 1; v.alu_src_b = 2'b01; v.pc_write = rdy; v.ir_write = rdy; end
         4'd1: v.alu_src_b = 2'b11;
         4'd2: begin v.alu_src_a = 1; v.alu_src_b = 2'b10; end
         4'd3: begin v.mem_read = 1; v.iord = 1; end
         4'd4: begin v.reg_write = 1; v.mem_to_reg = 1; end
         4'd5: begin v.mem_write = 1; v.iord = 1; end
         4'd6: begin v.alu_src_a = 1; v.alu_op = 3'b010; end
         4'd7: begin v.reg_write = 1; v.reg_dst = 1; end
         4'd8: begin
            v.alu_src_a = 1; v.alu_src_b = 2'b10;
            if (opc == 6'b001100) begin v.ext_sel = 2'b01; v.alu_op = 3'b011; end
            if (opc == 6'b001101) begin v.ext_sel = 2'b01; v.alu_op = 3'b100; end
            if (opc == 6'b001010) v.alu_op = 3'b101;
            if (opc == 6'b001111) begin v.ext_sel = 2'b10; v.alu_op = 3'b110; end
         end
         4'd9: v.reg_write = 1;
         4'd10: begin
            v.alu_src_a = 1; v.alu_op = 3'b001; v.pc_src = 2'b01;
            v.pc_write = (opc == 6'b000100) ? z : !z;
         end
         4'd11: begin v.pc_src = 2'b10; v.pc_write = 1; end
         default: v.illegal = 1;
      endcase
      return v;
   endfunction

   function automatic vec_t observe();
      vec_t v;
      v.st = state; v.pc_write = pc_write; v.ir_write = ir_write; v.iord = iord;
      v.mem_read = mem_read; v.mem_write = mem_write; v.reg_write = reg_write;
      v.reg_dst = reg_dst; v.mem_to_reg = mem_to_reg; v.alu_src_a = alu_src_a;
      v.alu_src_b = alu_src_b; v.ext_sel = ext_sel; v.alu_op = alu_op;
      v.pc_src = pc_src; v.illegal = illegal;
      return v;
   endfunction

   // Drive one cycle's inputs after the falling edge and queue the expectation.
   task automatic drive(input logic rdy, input logic z, input logic [3:0] st);
      @(negedge clk);
      mem_ready = rdy;
      alu_zero  = z;
      sb.push_back(ref_vec(st, opcode, rdy & rst_n, z));
      #1;
   endtask

   task automatic do_reset();
      mem_ready = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      vec_t got, exp;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b0, 4'd0);
         got = observe(); exp = sb.pop_front(); checks++;
         if (got !== exp) begin
            failures++; $display("FAIL reset step %0d got=%h exp=%h", i, got, exp);
         end
      end
      mem_ready = 1'b0;
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 4'd0);
      got = observe(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
         failures++; $display("FAIL reset_release got=%h exp=%h", got, exp);
      end
   endtask

   task automatic test_rtype();
      logic [3:0] sq [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
      logic       rq [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vec_t got, exp;
      int irw = 0;
      opcode = 6'b000000;
      for (int i = 0; i < 5; i++) begin
         drive(rq[i], 1'b0, sq[i]);
         got = observe(); exp = sb.pop_front(); checks++;
         if (got !== exp) begin
            failures++; $display("FAIL rtype step %0d got=%h exp=%h", i, got, exp);
         end
         if (i < 4) irw += int'(ir_write);
      end
      checks++;
      if (irw != 1) begin
         failures++; $display("FAIL rtype_ir_pulses got=%0d exp=1", irw);
      end
   endtask

   task automatic test_itype();
      logic [5:0] opc [5] = '{6'b001101, 6'b001111, 6'b001000, 6'b001100, 6'b001010};
      logic [1:0] ext [5] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b00};
      logic [2:0] aop [5] = '{3'b100, 3'b110, 3'b000, 3'b011, 3'b101};
      logic [3:0] sq  [5] = '{4'd0, 4'd1, 4'd8, 4'd9, 4'd0};
      logic       rq  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vec_t got, exp;
      for (int k = 0; k < 5; k++) begin
         opcode = opc[k];
         for (int i = 0; i < 5; i++) begin
            drive(rq[i], 1'b0, sq[i]);
            got = observe(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
               failures++; $display("FAIL itype op=%b step %0d got=%h exp=%h", opc[k], i, got, exp);
            end
            if (i == 2) begin
               checks++;
               if (ext_sel !== ext[k] || alu_op !== aop[k]) begin
                  failures++;
                  $display("FAIL itype_exec op=%b got ext=%b alu=%b exp ext=%b alu=%b",
                           opc[k], ext_sel, alu_op, ext[k], aop[k]);
               end
            end
         end
      end
   endtask

   task automatic test_mem();
      logic [3:0] lsq [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
      logic       lrq [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [3:0] ssq [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
      logic       srq [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vec_t got, exp;
      opcode = 6'b100011;
      for (int i = 0; i < 9; i++) begin
         drive(lrq[i], 1'b0, lsq[i]);
         got = observe(); exp = sb.pop_front(); checks++;
         if (got !== exp) begin
            failures++; $display("FAIL lw step %0d got=%h exp=%h", i, got, exp);
         end
      end
      opcode = 6'b101011;
      for (int i = 0; i < 5; i++) begin
         drive(srq[i], 1'b0, ssq[i]);
         got = observe(); exp = sb.pop_front(); checks++;
         if (got !== exp) begin
            failures++; $display("FAIL sw step %0d got=%h exp=%h", i, got, exp);
         end
      end
   endtask

   task automatic test_branch();
      logic [5:0] opc [5] = '{6'b000100, 6'b000100, 6'b000101, 6'b000101, 6'b000010};
      logic       zz  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic       pcw [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [3:0] xs  [5] = '{4'd10, 4'd10, 4'd10, 4'd10, 4'd11};
      logic [3:0] sq [4];
      logic       rq [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      vec_t got, exp;
      for (int k = 0; k < 5; k++) begin
         opcode = opc[k];
         sq = '{4'd0, 4'd1, xs[k], 4'd0};
         for (int i = 0; i < 4; i++) begin
            drive(rq[i], zz[k], sq[i]);
            got = observe(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
               failures++; $display("FAIL branch op=%b z=%b step %0d got=%h exp=%h",
                                    opc[k], zz[k], i, got, exp);
            end
            if (i == 2) begin
               checks++;
               if (pc_write !== pcw[k]) begin
                  failures++; $display("FAIL branch_pcw op=%b got=%b exp=%b", opc[k], pc_write, pcw[k]);
               end
            end
         end
      end
   endtask

   task automatic test_illegal();
      vec_t got, exp;
      opcode = 6'b111111;
      for (int i = 0; i < 24; i++) begin
         drive((i < 2) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0,
               (i == 0) ? 4'd0 : (i == 1) ? 4'd1 : 4'd15);
         got = observe(); exp = sb.pop_front(); checks++;
         if (got !== exp) begin
            failures++; $display("FAIL illegal step %0d got=%h exp=%h", i, got, exp);
         end
      end
      do_reset();
   endtask

   task automatic test_timeout();
      logic [3:0] sq[$];
      logic       rq[$];
      vec_t got, exp;
      opcode = 6'b000000;
      do_reset();
      for (int i = 0; i < 16; i++) begin sq.push_back(4'd0); rq.push_back(1'b0); end
      for (int i = 0; i < 3; i++)  begin sq.push_back(4'd15); rq.push_back(1'b0); end
      foreach (sq[i]) begin
         drive(rq[i], 1'b0, sq[i]);
         got = observe(); exp = sb.pop_front(); checks++;
         if (got !== exp) begin
            failures++; $display("FAIL timeout step %0d got=%h exp=%h", i, got, exp);
         end
      end
      do_reset();
      sq.delete(); rq.delete();
      for (int i = 0; i < 15; i++) begin sq.push_back(4'd0); rq.push_back(1'b0); end
      sq.push_back(4'd0); rq.push_back(1'b1);
      sq.push_back(4'd1); rq.push_back(1'b0);
      sq.push_back(4'd6); rq.push_back(1'b0);
      sq.push_back(4'd7); rq.push_back(1'b0);
      sq.push_back(4'd0); rq.push_back(1'b0);
      foreach (sq[i]) begin
         drive(rq[i], 1'b0, sq[i]);
         got = observe(); exp = sb.pop_front(); checks++;
         if (got !== exp) begin
            failures++; $display("FAIL no_timeout step %0d got=%h exp=%h", i, got, exp);
         end
      end
   endtask

   task automatic test_reset_mid_write();
      logic [3:0] sq [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
      logic       rq [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vec_t got, exp;
      opcode = 6'b101011;
      for (int i = 0; i < 5; i++) begin
         drive(rq[i], 1'b0, sq[i]);
         got = observe(); exp = sb.pop_front(); checks++;
         if (got !== exp) begin
            failures++; $display("FAIL midwrite step %0d got=%h exp=%h", i, got, exp);
         end
      end
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (mem_write !== 1'b0 || state !== 4'd0) begin
         failures++; $display("FAIL async_reset got mem_write=%b state=%0d exp mem_write=0 state=0",
                              mem_write, state);
      end
      drive(1'b1, 1'b0, 4'd0);
      got = observe(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
         failures++; $display("FAIL midwrite_held_reset got=%h exp=%h", got, exp);
      end
      mem_ready = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1; mem_ready = 1'b0; alu_zero = 1'b0; opcode = 6'b000000;
      #2 rst_n = 1'b0;
      test_reset();
      test_rtype();
      test_itype();
      test_mem();
      test_branch();
      test_illegal();
      test_timeout();
      test_reset_mid_write();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multicycle Moore control FSM for the 32-bit MIPS datapath. It sequences fetch/decode/execute/memory/writeback and drives the immediate-extension select (sign, zero or lui) and the ALU operand muxes. It holds the memory handshake and traps on illegal opcodes or memory timeout. It sits between the instruction register (opcode/funct) and the datapath mux, ALU and write enables.

Parameters:
MEM_WAIT_MAX, 16, maximum cycles a memory access may wait for mem_ready before TRAP (range 2..31).
CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > MEM_WAIT_MAX.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  6  IR[31:26]; stable from DECODE until the next FETCH
alu_zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current read/write this cycle
pc_write  output  1  PC load enable
ir_write  output  1  IR load enable
iord  output  1  memory address select: 0=PC, 1=ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
reg_write  output  1  register file write enable
reg_dst  output  1  destination register: 0=rt, 1=rd
mem_to_reg  output  1  writeback source: 0=ALUOut, 1=MDR
alu_src_a  output  1  ALU A: 0=PC, 1=rs
alu_src_b  output  2  ALU B: 00=rt, 01=const 4, 10=ext imm, 11=ext imm<<2
ext_sel  output  2  immediate extender: 00=sign, 01=zero, 10=imm<<16 (lui)
alu_op  output  3  000 ADD, 001 SUB, 010 FUNCT, 011 AND, 100 OR, 101 SLT, 110 PASS_B
pc_src  output  2  PC source: 00=ALU, 01=ALUOut (branch target), 10=jump target
state  output  4  current state code, for debug
illegal  output  1  high only in TRAP

Behaviour:
- Reset (async, rst_n=0): state=FETCH (0), wait counter=0. Outputs take FETCH decode values, except pc_write=ir_write=0 because mem_ready is ignored while in reset. On release, the first fetch starts at the next edge.
- Outputs are a pure decode of state. Exceptions: pc_write/ir_write in FETCH are gated by mem_ready, and pc_write in BRANCH is gated by alu_zero. Every output not listed for a state is 0.
- State codes: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, I_EXEC 8, I_WB 9, BRANCH 10, JUMP 11, TRAP 15.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, ADD. On mem_ready=1: ir_write=1, pc_write=1, next state DECODE; otherwise stay.
- DECODE: alu_src_a=0, alu_src_b=11, ext_sel=00, ADD (branch target precompute). Dispatch by opcode:
  - 000000 -> R_EXEC
  - 100011 (lw) or 101011 (sw) -> MEM_ADDR
  - 000100 (beq) or 000101 (bne) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000 addi, 001100 andi, 001101 ori, 001010 slti, 001111 lui -> I_EXEC
  - any other opcode -> TRAP
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ext_sel=00, ADD. Next state MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read=1, iord=1. On mem_ready go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; next state FETCH.
- MEM_WRITE: mem_write=1, iord=1. On mem_ready go to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, FUNCT; next state R_WB.
- R_WB: reg_write=1, reg_dst=1; next state FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10. Per opcode:
  - addi: ext 00, ADD
  - andi: ext 01, AND
  - ori: ext 01, OR
  - slti: ext 00, SLT
  - lui: ext 10, PASS_B
  - Next state I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0; next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01. pc_write=alu_zero for beq, !alu_zero for bne. Next state FETCH.
- JUMP: pc_src=10, pc_write=1; next state FETCH.
- Wait counter:
  - Counts consecutive cycles in FETCH/MEM_READ/MEM_WRITE with mem_ready=0.
  - Clears on mem_ready=1 and on any state change.
  - If the counter equals MEM_WAIT_MAX-1 and mem_ready=0, next state is TRAP.
  - mem_ready=1 in that same cycle wins: the access completes normally.
- TRAP: illegal=1, all enables 0, absorbing; only rst_n leaves it.
- Request hold: mem_read/mem_write stay asserted continuously until mem_ready, with no dropouts.
- Reset mid-access: the request drops immediately (async); nothing is written.
- CPI: R/I-type 4, lw 5, sw 4, branch/jump 3, each with zero-wait memory.

Test Plan:
- Reset, then add (opcode 000000), mem_ready tied 1 -> states 0,1,6,7,0; reg_write=1 and reg_dst=1 only in state 7; ir_write pulses once.
- ori (001101) and lui (001111) -> ext_sel=01 with alu_op=100 in I_EXEC; ext_sel=10 with alu_op=110; addi (001000) -> ext_sel=00, alu_op=000.
- lw with mem_ready low 3 cycles in MEM_READ -> state 3 held 4 cycles, mem_read=1 throughout, then MEM_WB with mem_to_reg=1; sw -> mem_write=1, no reg_write.
- beq with alu_zero=1 -> pc_write=1, pc_src=01; bne with alu_zero=1 -> pc_write=0; j -> pc_write=1, pc_src=10; each returns to FETCH after 3 cycles.
- opcode 111111 -> TRAP, illegal=1, stays 20+ cycles; mem_ready stuck 0 in FETCH -> TRAP after exactly 16 cycles; mem_ready=1 on the 16th cycle -> no trap.
- rst_n pulsed low during MEM_WRITE wait -> mem_write drops in the same cycle, state=0 asynchronously.
